nanorv32_tcm_arbiter: RTL and testbench

Arbiter sharing the single-port TCM between the nanorv32 instruction-fetch port and the load/store data port. Each cycle it grants at most one requester, drives the TCM with a one-cycle-latency read/write, and routes the returned word back to the requester that issued it. Data accesses have fixed priority over fetches. An optional starvation guard bounds how long fetch can wait. It sits between U_CPU and the u_tcm0 RAM inside the nanorv32 top level.

---
 rtl/nanorv32_tcm_arbiter_pkg.sv | 13 +
 rtl/nanorv32_tcm_arbiter_if.sv | 45 ++++
 rtl/nanorv32_tcm_arbiter_starve_cnt.sv | 38 +++
 rtl/nanorv32_tcm_arbiter.sv | 83 ++++++++
 tb/tb_nanorv32_tcm_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nanorv32_tcm_arbiter_pkg.sv
// Shared types for the nanorv32 TCM arbiter: response-owner encoding and bus widths.
package nanorv32_tcm_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_sel_e;

endpackage

// File: rtl/nanorv32_tcm_arbiter_if.sv
// Bundle of the fetch port, data port and TCM port around the arbiter.
// slave = arbiter side; master = the CPU/TCM environment that surrounds it.
interface nanorv32_tcm_arbiter_if #(parameter int ADDR_W = 16);
  import nanorv32_tcm_arbiter_pkg::*;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_rdata;

  logic              d_req_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [STRB_W-1:0] d_req_wstrb;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;

  logic              mem_cs;
  logic [STRB_W-1:0] mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    output d_req_valid, d_req_addr, d_req_we, d_req_wstrb, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/nanorv32_tcm_arbiter_starve_cnt.sv
// Fetch starvation guard: counts cycles a pending fetch loses to data and raises
// forceFetch_o once the count reaches MAX_WAIT. Only used with NANORV32_TCM_ARB_STARVE_EN.
module nanorv32_tcm_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifValid_i,
  input  logic ifGrant_i,
  output logic forceFetch_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  // Saturates at MAX_CNT so the force flag stays up until fetch actually wins.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!ifValid_i || ifGrant_i) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != MAX_CNT) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end

  assign forceFetch_o = (waitCnt_q == MAX_CNT);

endmodule

// File: rtl/nanorv32_tcm_arbiter.sv
// Single-port TCM arbiter between nanorv32 fetch and load/store ports; data wins ties.
// Define NANORV32_TCM_ARB_STARVE_EN to bound fetch starvation to MAX_WAIT lost cycles.
module nanorv32_tcm_arbiter
  import nanorv32_tcm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst_n,
  nanorv32_tcm_arbiter_if.slave bus
);

  logic     ifGrant, dGrant, forceFetch;
  rsp_sel_e rspSel_q, rspSel_d;
  logic     isWr_q, isWr_d;
  logic     unusedAddrBits;

  assign unusedAddrBits = ^{bus.if_req_addr[1:0], bus.d_req_addr[1:0]};

`ifdef NANORV32_TCM_ARB_STARVE_EN
  nanorv32_tcm_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) uStarveCnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifValid_i   (bus.if_req_valid),
    .ifGrant_i   (ifGrant),
    .forceFetch_o(forceFetch)
  );
`else
  assign forceFetch = 1'b0;
`endif

  // Reset gates every grant, so readies and the TCM strobe stay low while rst_n = 0.
  always_comb begin
    ifGrant = 1'b0;
    dGrant  = 1'b0;
    if (rst_n) begin
      if (bus.d_req_valid && !(forceFetch && bus.if_req_valid)) begin
        dGrant = 1'b1;
      end else if (bus.if_req_valid) begin
        ifGrant = 1'b1;
      end
    end
  end

  assign bus.if_req_ready = ifGrant;
  assign bus.d_req_ready  = dGrant;
  assign bus.mem_cs       = ifGrant | dGrant;
  assign bus.mem_we       = (dGrant && bus.d_req_we) ? bus.d_req_wstrb : '0;
  assign bus.mem_wdata    = dGrant ? bus.d_req_wdata : '0;
  assign bus.mem_addr     = dGrant  ? bus.d_req_addr[ADDR_W-1:2] :
                            ifGrant ? bus.if_req_addr[ADDR_W-1:2] : '0;

  always_comb begin
    rspSel_d = RSP_NONE;
    isWr_d   = 1'b0;
    if (dGrant) begin
      rspSel_d = RSP_D;
      isWr_d   = bus.d_req_we;
    end else if (ifGrant) begin
      rspSel_d = RSP_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rspSel_q <= RSP_NONE;
      isWr_q   <= 1'b0;
    end else begin
      rspSel_q <= rspSel_d;
      isWr_q   <= isWr_d;
    end
  end

  // Responses are also gated by rst_n so an access accepted just before reset never answers.
  assign bus.if_rsp_valid = rst_n && (rspSel_q == RSP_IF);
  assign bus.d_rsp_valid  = rst_n && (rspSel_q == RSP_D);
  assign bus.if_rsp_rdata = bus.if_rsp_valid ? bus.mem_rdata : '0;
  assign bus.d_rsp_rdata  = (bus.d_rsp_valid && !isWr_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_nanorv32_tcm_arbiter.sv
// Scoreboard bench for nanorv32_tcm_arbiter: directed scenarios plus random traffic,
// checked against a word-level memory model with fixed data priority.
module tb_nanorv32_tcm_arbiter;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << (ADDR_W - 2);
`ifdef NANORV32_TCM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanorv32_tcm_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  nanorv32_tcm_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ram    [WORDS];
  logic [31:0] refMem [WORDS];
  logic [31:0] ramRdata = '0;
  logic [31:0] ramMerge;
  logic [31:0] ifQ[$];
  logic [31:0] dQ[$];
  int          lostCycles = 0;

  assign bus.mem_rdata = ramRdata;

  // Write-first single-port TCM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      ramMerge = ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ramMerge[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      ram[bus.mem_addr] <= ramMerge;
      ramRdata          <= ramMerge;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  // Monitor: retire last cycle's predictions, then predict this cycle's grant and response.
  always @(negedge clk) begin
    logic [31:0] expv;
    logic [13:0] wa;
    bit          expIf, expD, forceIf;
    if (!rst_n) begin
      ifQ.delete();
      dQ.delete();
      lostCycles = 0;
      checkOutput("rst_if_ready", 32'(bus.if_req_ready), 0);
      checkOutput("rst_d_ready", 32'(bus.d_req_ready), 0);
      checkOutput("rst_mem_cs", 32'(bus.mem_cs), 0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
      checkOutput("rst_if_rsp_valid", 32'(bus.if_rsp_valid), 0);
      checkOutput("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 0);
      checkOutput("rst_if_rsp_rdata", bus.if_rsp_rdata, 0);
      checkOutput("rst_d_rsp_rdata", bus.d_rsp_rdata, 0);
    end else begin
      if (ifQ.size() != 0) begin
        expv = ifQ.pop_front();
        checkOutput("if_rsp_valid", 32'(bus.if_rsp_valid), 1);
        checkOutput("if_rsp_rdata", bus.if_rsp_rdata, expv);
      end else begin
        checkOutput("if_rsp_idle_valid", 32'(bus.if_rsp_valid), 0);
        checkOutput("if_rsp_idle_rdata", bus.if_rsp_rdata, 0);
      end
      if (dQ.size() != 0) begin
        expv = dQ.pop_front();
        checkOutput("d_rsp_valid", 32'(bus.d_rsp_valid), 1);
        checkOutput("d_rsp_rdata", bus.d_rsp_rdata, expv);
      end else begin
        checkOutput("d_rsp_idle_valid", 32'(bus.d_rsp_valid), 0);
        checkOutput("d_rsp_idle_rdata", bus.d_rsp_rdata, 0);
      end

      forceIf = STARVE && bus.if_req_valid && (lostCycles >= MAX_WAIT);
      expD    = bus.d_req_valid && !forceIf;
      expIf   = bus.if_req_valid && !expD;
      checkOutput("d_req_ready", 32'(bus.d_req_ready), 32'(expD));
      checkOutput("if_req_ready", 32'(bus.if_req_ready), 32'(expIf));
      checkOutput("mem_cs", 32'(bus.mem_cs), 32'(expD || expIf));

      if (expD) begin
        wa = bus.d_req_addr[15:2];
        checkOutput("mem_addr_d", 32'(bus.mem_addr), 32'(wa));
        checkOutput("mem_we_d", 32'(bus.mem_we), bus.d_req_we ? 32'(bus.d_req_wstrb) : 0);
        checkOutput("mem_wdata_d", bus.mem_wdata, bus.d_req_wdata);
        if (bus.d_req_we) begin
          refMem[wa] = mergeWrite(refMem[wa], bus.d_req_wdata, bus.d_req_wstrb);
          dQ.push_back(32'h0);
        end else begin
          dQ.push_back(refMem[wa]);
        end
      end else if (expIf) begin
        wa = bus.if_req_addr[15:2];
        checkOutput("mem_addr_if", 32'(bus.mem_addr), 32'(wa));
        checkOutput("mem_we_if", 32'(bus.mem_we), 0);
        ifQ.push_back(refMem[wa]);
      end else begin
        checkOutput("mem_we_idle", 32'(bus.mem_we), 0);
      end

      if (bus.if_req_valid && !expIf) lostCycles = (lostCycles < MAX_WAIT) ? lostCycles + 1 : MAX_WAIT;
      else lostCycles = 0;
    end
  end

  task automatic applyStimulus(input bit ifV, input logic [15:0] ifA, input bit dV,
                               input logic [15:0] dA, input bit we, input logic [3:0] strb,
                               input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.if_req_valid = ifV;
    bus.if_req_addr  = ifA;
    bus.d_req_valid  = dV;
    bus.d_req_addr   = dA;
    bus.d_req_we     = we;
    bus.d_req_wstrb  = strb;
    bus.d_req_wdata  = wd;
  endtask

  initial begin
    bit          ifV, dV, dWe, ifPend, dPend;
    logic [15:0] ifA, dA;
    logic [3:0]  dStrb;
    logic [31:0] dWd;

    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = '0;
    bus.d_req_we     = 1'b0;
    bus.d_req_wstrb  = '0;
    bus.d_req_wdata  = '0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]    = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      refMem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    end

    $display("[TB] reset with both requesters pending");
    repeat (3) applyStimulus(1, 16'h0000, 1, 16'h0010, 1, 4'hF, 32'h1111_1111);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] fetch-only stream");
    applyStimulus(1, 16'h0000, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'h0004, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'h0008, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] partial write then read-back");
    applyStimulus(0, 0, 1, 16'h0040, 1, 4'b0011, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 1, 16'h0040, 0, 4'b0000, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] single-cycle collision");
    applyStimulus(1, 16'h0010, 1, 16'h0020, 0, 0, 0);
    applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] sustained collision");
    repeat (12) applyStimulus(1, 16'h0014, 1, 16'h0024, 0, 0, 0);
    applyStimulus(1, 16'h0014, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset right after a data read");
    applyStimulus(0, 0, 1, 16'h0044, 0, 0, 0);
    applyStimulus(1, 16'h0008, 1, 16'h0048, 1, 4'hF, 32'hCAFE_F00D);
    rst_n = 1'b0;
    applyStimulus(1, 16'h0008, 1, 16'h0048, 1, 4'hF, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1, 16'h000C, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] alternating owners");
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) applyStimulus(0, 0, 1, 16'(16'h0080 + i * 4), 0, 0, 0);
      else            applyStimulus(1, 16'(16'h0100 + i * 4), 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    ifPend = 0; dPend = 0;
    ifV = 0; dV = 0; dWe = 0; ifA = '0; dA = '0; dStrb = '0; dWd = '0;
    for (int i = 0; i < 500; i++) begin
      if (!ifPend) begin
        ifV = ($urandom_range(0, 3) != 0);
        ifA = 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      end
      if (!dPend) begin
        dV    = $urandom_range(0, 1) == 1;
        dA    = 16'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        dWe   = $urandom_range(0, 1) == 1;
        dStrb = 4'($urandom);
        dWd   = $urandom;
      end
      applyStimulus(ifV, ifA, dV, dA, dWe, dStrb, dWd);
      @(negedge clk);
      ifPend = ifV && !bus.if_req_ready;
      dPend  = dV && !bus.d_req_ready;
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("queues_drained", 32'(ifQ.size() + dQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
